seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen_pkg.sv | 25 ++
 rtl/seq_shreg.sv | 33 +++
 rtl/seq_gen.sv | 161 ++++++++++++++++
 tb/tb_seq_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence-detector blocks.
// Holds the pattern width, the FSM state codes and a small pattern-select helper.
package seq_gen_pkg;

    localparam int PAT_W     = 4;
    localparam int BIT_CNT_W = 2;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SHIFT = 3'b001,
        ST_GAP   = 3'b010,
        ST_DONE  = 3'b011
    } state_e;

    function automatic logic [PAT_W-1:0] pick_pattern(
        input logic             sel_bit,
        input logic [PAT_W-1:0] pat_a,
        input logic [PAT_W-1:0] pat_b
    );
        return sel_bit ? pat_b : pat_a;
    endfunction

endpackage

// File: rtl/seq_shreg.sv
// Loadable left shift register; the MSB is the bit currently presented on the serial line.
module seq_shreg
    import seq_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] data_r;

    // Pattern storage: load has priority over shifting; zeros fill from the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {PAT_W{1'b0}};
        end else if (srst) begin
            data_r <= {PAT_W{1'b0}};
        end else if (load) begin
            data_r <= din;
        end else if (shift_en) begin
            data_r <= {data_r[PAT_W-2:0], 1'b0};
        end else begin
            data_r <= data_r;
        end
    end

    assign msb = data_r[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends PAT_A or PAT_B MSB first, 1..4 times with a one-cycle
// idle gap between repetitions, then a one-cycle done pulse.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter logic [PAT_W-1:0] PAT_A      = 4'b1101,
    parameter logic [PAT_W-1:0] PAT_B      = 4'b0010,
    parameter logic             IDLE_LEVEL = 1'b0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sel,
    input  logic [1:0] reps,
    input  logic       abort,
    output logic       w,
    output logic       busy,
    output logic       done,
    output logic [2:0] sLED
);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [1:0]             rep_cnt_r;
    logic                   sel_r;
    logic                   accept_s;
    logic                   load_s;
    logic                   shift_en_s;
    logic                   clr_s;
    logic [PAT_W-1:0]       load_data_s;
    logic                   msb_s;

    // Next-state and datapath control; abort overrides everything, illegal codes fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        load_s      = 1'b0;
        shift_en_s  = 1'b0;
        clr_s       = 1'b0;
        load_data_s = PAT_A;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            clr_s       = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_SHIFT;
                        accept_s    = 1'b1;
                        load_s      = 1'b1;
                        load_data_s = pick_pattern(sel, PAT_A, PAT_B);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        if (rep_cnt_r != 2'd0) begin
                            state_nxt_s = ST_GAP;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    state_nxt_s = ST_SHIFT;
                    load_s      = 1'b1;
                    load_data_s = pick_pattern(sel_r, PAT_A, PAT_B);
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    clr_s       = 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bit counter, repeat counter and latched select; sel/reps only sampled on an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= 2'b00;
            rep_cnt_r <= 2'b00;
            sel_r     <= 1'b0;
        end else if (clr_s) begin
            bit_cnt_r <= 2'b00;
            rep_cnt_r <= 2'b00;
            sel_r     <= 1'b0;
        end else begin
            if (load_s) begin
                bit_cnt_r <= 2'b00;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 2'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (accept_s) begin
                rep_cnt_r <= reps;
                sel_r     <= sel;
            end else if (shift_en_s && (bit_cnt_r == LAST_BIT) && (rep_cnt_r != 2'd0)) begin
                rep_cnt_r <= rep_cnt_r - 2'd1;
                sel_r     <= sel_r;
            end else begin
                rep_cnt_r <= rep_cnt_r;
                sel_r     <= sel_r;
            end
        end
    end

    seq_shreg u_shreg (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (clr_s),
        .load     (load_s),
        .shift_en (shift_en_s),
        .din      (load_data_s),
        .msb      (msb_s)
    );

    // Output decode from registered state and shift-register MSB only.
    always_comb begin
        w    = IDLE_LEVEL;
        busy = 1'b0;
        done = 1'b0;
        sLED = state_r;
        case (state_r)
            ST_SHIFT: begin
                w    = msb_s;
                busy = 1'b1;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                w    = IDLE_LEVEL;
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: a transaction-level expected-trace model checked every
// cycle, plus literal expectations for the reference sequences.
module tb_seq_gen;

    localparam logic [3:0] PA = 4'b1101;
    localparam logic [3:0] PB = 4'b0010;
    localparam logic       IL = 1'b0;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sel   = 1'b0;
    logic [1:0] reps  = 2'b00;
    logic       abort = 1'b0;
    logic       w, busy, done;
    logic [2:0] sLED;

    int tests = 0;
    int fails = 0;
    int det_cnt = 0;
    logic [3:0] det_win = 4'b0000;

    always #5 clk = ~clk;

    seq_gen dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sel   (sel),
        .reps  (reps),
        .abort (abort),
        .w     (w),
        .busy  (busy),
        .done  (done),
        .sLED  (sLED)
    );

    typedef struct packed {
        logic       w;
        logic       busy;
        logic       done;
        logic [2:0] sled;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // A whole accepted transmission expands into its per-cycle expected outputs.
    task automatic push_trace(input logic s, input logic [1:0] r);
        logic [3:0] p;
        p = s ? PB : PA;
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = 3; b >= 0; b--)
                q.push_back('{w: p[b], busy: 1'b1, done: 1'b0, sled: 3'b001});
            if (k < int'(r))
                q.push_back('{w: IL, busy: 1'b1, done: 1'b0, sled: 3'b010});
        end
        q.push_back('{w: IL, busy: 1'b0, done: 1'b1, sled: 3'b011});
    endtask

    // Model: empty queue means idle; start accepted only from idle; abort/reset discard the rest.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset || abort) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (start) push_trace(sel, reps);
            end else begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) e = '{w: IL, busy: 1'b0, done: 1'b0, sled: 3'b000};
            else               e = q[0];
            check("cycle", {2'b00, w, busy, done, sLED}, {2'b00, e});
        end
    end

    // Loopback sequence detector for PAT_A on the serial line.
    initial begin
        forever begin
            @(negedge clk);
            det_win = {det_win[2:0], w};
            if (det_win == PA) det_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic pulse_start(input logic s, input logic [1:0] r);
        @(posedge clk); #1;
        start = 1'b1; sel = s; reps = r;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sLED == 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", 8'(ok), 8'd1);
    endtask

    initial begin
        logic [5:0]  ew6;
        logic [2:0]  esl [6];
        logic [13:0] ew14;
        int busy_n, done_n, gap_n, det_base;

        // Reset values
        #12;
        check("rst_w", 8'(w), 8'(IL));
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_sled", 8'(sLED), 8'd0);
        @(posedge clk); #1 reset = 1'b1;

        // PAT_A once
        ew6 = 6'b110100;
        esl = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
        busy_n = 0;
        pulse_start(1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("a_w", 8'(w), 8'(ew6[5-i]));
            check("a_sled", 8'(sLED), 8'(esl[i]));
            check("a_done", 8'(done), (i == 4) ? 8'd1 : 8'd0);
            if (busy) busy_n++;
        end
        check("a_busy_len", 8'(busy_n), 8'd4);

        // PAT_B three times
        ew14 = 14'b0010_0_0010_0_0010;
        busy_n = 0; done_n = 0; gap_n = 0;
        pulse_start(1'b1, 2'd2);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i < 14) check("b_w", 8'(w), 8'(ew14[13-i]));
            if (busy) busy_n++;
            if (done) done_n++;
            if (sLED == 3'b010) gap_n++;
        end
        check("b_busy_len", 8'(busy_n), 8'd14);
        check("b_done_cnt", 8'(done_n), 8'd1);
        check("b_gap_cnt", 8'(gap_n), 8'd2);

        // Abort on the third SHIFT cycle, then a normal transmission
        pulse_start(1'b0, 2'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_sled", 8'(sLED), 8'd0);
        check("abort_w", 8'(w), 8'(IL));
        pulse_start(1'b0, 2'd1);
        wait_idle();

        // sel/reps/start changes while busy are ignored
        pulse_start(1'b0, 2'd1);
        @(posedge clk); #1 sel = 1'b1; reps = 2'd3; start = 1'b1;
        @(posedge clk); #1 sel = 1'b0; reps = 2'd0;
        @(posedge clk); #1 sel = 1'b1; reps = 2'd2; start = 1'b0;
        wait_idle();
        @(negedge clk);
        check("no_restart", 8'(sLED), 8'd0);

        // start held through DONE is accepted once IDLE is reached
        @(posedge clk); #1 start = 1'b1; sel = 1'b0; reps = 2'd0;
        repeat (7) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("held_start", 8'(sLED), 8'd1);
        wait_idle();

        // abort beats start in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_prio", 8'(sLED), 8'd0);

        // Async reset mid-GAP
        det_base = det_cnt;
        pulse_start(1'b0, 2'd1);
        repeat (3) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        check("pre_rst_gap", 8'(sLED), 8'd2);
        #1 reset = 1'b0;
        #1;
        check("arst_w", 8'(w), 8'(IL));
        check("arst_busy", 8'(busy), 8'd0);
        check("arst_done", 8'(done), 8'd0);
        check("arst_sled", 8'(sLED), 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 8'(sLED), 8'd0);
        end
        check("det_count", 8'(det_cnt - det_base), 8'd1);
        pulse_start(1'b1, 2'd0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
